// File: rtl/tt_fetch_pkg.sv
// ============================================================================
// Module      : tt_fetch_pkg
// Description : Shared constants for the byte-wide instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_fetch_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ_HI  = 3'd1;
  localparam logic [2:0] ST_REQ_LO  = 3'd2;
  localparam logic [2:0] ST_SEND_HI = 3'd3;
  localparam logic [2:0] ST_SEND_LO = 3'd4;

  localparam int MEM_ACK  = 0;
  localparam int IR_READY = 1;
  localparam int JUMP     = 2;
  localparam int MEM_REQ  = 4;
  localparam int IR_VALID = 5;
  localparam int BYTE_SEL = 6;
  localparam int FAULT    = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

`default_nettype wire

// File: rtl/fetch_timeout_counter.sv
// ============================================================================
// Module      : fetch_timeout_counter
// Description : Saturating wait counter; reached is high on the cycle whose
//               increment lands on TIMEOUT, and while saturated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic reached
);

  localparam logic [7:0] c_limit = 8'(TIMEOUT);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (clr) begin
      r_count <= 8'd0;
    end else if (en && (r_count != c_limit)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign reached = (r_count == c_limit) | (en & (r_count == (c_limit - 8'd1)));

endmodule

`default_nettype wire

// File: rtl/tt_um_instruction_fetch.sv
// ============================================================================
// Module      : tt_um_instruction_fetch
// Description : 8-bit PC fetch unit; reads 16-bit instructions as two bytes
//               and hands them to the instruction register as two beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_instruction_fetch
  import tt_fetch_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_start_pc;
  logic [7:0] r_hi;
  logic [7:0] r_lo;
  logic       r_fault;

  logic w_ack;
  logic w_ready;
  logic w_jump;
  logic w_in_req;
  logic w_in_send;
  logic w_jump_taken;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_reached;
  logic w_unused;

  assign w_ack     = uio_in[MEM_ACK];
  assign w_ready   = uio_in[IR_READY];
  assign w_jump    = uio_in[JUMP];
  assign w_unused  = &{1'b0, uio_in[7:3]};

  assign w_in_req     = (r_state == ST_REQ_HI) || (r_state == ST_REQ_LO);
  assign w_in_send    = (r_state == ST_SEND_HI) || (r_state == ST_SEND_LO);
  assign w_jump_taken = w_jump && !w_in_send;

  // Count only genuine waiting cycles; any way out of a REQ state restarts it.
  assign w_tmr_en  = w_in_req && ena && !w_jump && !w_ack;
  assign w_tmr_clr = !w_in_req || !ena || w_jump || w_ack;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_tmr_clr),
    .en      (w_tmr_en),
    .reached (w_reached)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_start_pc <= RESET_PC;
      r_hi       <= 8'h00;
      r_lo       <= 8'h00;
      r_fault    <= 1'b0;
    end else if (w_jump_taken) begin
      r_pc       <= ui_in;
      r_start_pc <= ui_in;
      r_fault    <= 1'b0;
      r_state    <= ena ? ST_REQ_HI : ST_IDLE;
    end else begin
      if (w_tmr_en && w_reached) begin
        r_fault <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (ena) begin
            r_start_pc <= r_pc;
            r_state    <= ST_REQ_HI;
          end
        end
        ST_REQ_HI: begin
          if (!ena) begin
            r_pc    <= r_start_pc;
            r_state <= ST_IDLE;
          end else if (w_ack) begin
            r_hi    <= ui_in;
            r_pc    <= r_pc + 8'd1;
            r_state <= ST_REQ_LO;
          end
        end
        ST_REQ_LO: begin
          if (!ena) begin
            r_pc    <= r_start_pc;
            r_state <= ST_IDLE;
          end else if (w_ack) begin
            r_lo    <= ui_in;
            r_pc    <= r_pc + 8'd1;
            r_state <= ST_SEND_HI;
          end
        end
        ST_SEND_HI: begin
          if (w_ready) begin
            r_state <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          if (w_ready) begin
            if (ena) begin
              r_start_pc <= r_pc;
              r_state    <= ST_REQ_HI;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    uo_out  = r_pc;
    uio_out = 8'h00;
    case (r_state)
      ST_REQ_HI, ST_REQ_LO: uio_out[MEM_REQ] = 1'b1;
      ST_SEND_HI: begin
        uo_out            = r_hi;
        uio_out[IR_VALID] = 1'b1;
      end
      ST_SEND_LO: begin
        uo_out            = r_lo;
        uio_out[IR_VALID] = 1'b1;
        uio_out[BYTE_SEL] = 1'b1;
      end
      default: begin
        uo_out = r_pc;
      end
    endcase
    uio_out[FAULT] = r_fault;
  end

  assign uio_oe = UIO_OE_MASK;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_instruction_fetch.sv
// ============================================================================
// Module      : tb_tt_um_instruction_fetch
// Description : Directed bench for the fetch unit with a byte memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_um_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic       ack;
  logic       ready;
  logic       jump;
  logic       drive_jump;
  logic [7:0] jump_val;
  logic [7:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign uio_in = {5'b0, jump, ready, ack};
  assign ui_in  = drive_jump ? jump_val : mem[uo_out];

  tt_um_instruction_fetch #(
    .RESET_PC (8'h00),
    .TIMEOUT  (15)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] uo, input logic [7:0] uio);
    chk({tag, ".uo"}, uo_out, uo);
    chk({tag, ".uio"}, uio_out, uio);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // uio_out encodings: 10 = mem_req, 20 = ir_valid hi, 60 = ir_valid lo, +80 fault
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34;
    mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
    mem[8'hFF] = 8'hAB;
    mem[8'h40] = 8'h9A; mem[8'h41] = 8'hBC;
    mem[8'h42] = 8'h11; mem[8'h43] = 8'h22;
    mem[8'h10] = 8'h5E; mem[8'h11] = 8'h6F;

    rst_n = 1'b0; ena = 1'b0; ack = 1'b0; ready = 1'b0; jump = 1'b0;
    drive_jump = 1'b0; jump_val = 8'h00;
    #12;
    expect_out("reset", 8'h00, 8'h00);
    chk("oe", uio_oe, 8'hF0);
    rst_n = 1'b1;

    // Basic fetch, both handshakes always ready
    ack = 1'b1; ready = 1'b1; ena = 1'b1;
    step(); expect_out("f_req_hi", 8'h00, 8'h10);
    step(); expect_out("f_req_lo", 8'h01, 8'h10);
    step(); expect_out("f_send_hi", 8'h12, 8'h20);
    step(); expect_out("f_send_lo", 8'h34, 8'h60);
    step(); expect_out("f_next", 8'h02, 8'h10);

    // Backpressure on the high beat
    ready = 1'b0;
    step(); expect_out("bp_req_lo", 8'h03, 8'h10);
    for (int i = 0; i < 5; i++) begin
      step(); expect_out("bp_hold", 8'h56, 8'h20);
    end
    ready = 1'b1;
    step(); expect_out("bp_lo", 8'h78, 8'h60);
    ena = 1'b0;
    step(); expect_out("idle", 8'h04, 8'h00);

    // Jump from IDLE to FF, instruction straddles the PC wrap
    mem[8'h00] = 8'hCD;
    jump = 1'b1; drive_jump = 1'b1; jump_val = 8'hFF; ena = 1'b1;
    step(); expect_out("w_req_hi", 8'hFF, 8'h10);
    jump = 1'b0; drive_jump = 1'b0;
    step(); expect_out("w_req_lo", 8'h00, 8'h10);
    step(); expect_out("w_send_hi", 8'hAB, 8'h20);
    step(); expect_out("w_send_lo", 8'hCD, 8'h60);
    step(); expect_out("w_next", 8'h01, 8'h10);

    // Jump beats a simultaneous ack in REQ_LO
    step(); expect_out("j_req_lo", 8'h02, 8'h10);
    jump = 1'b1; drive_jump = 1'b1; jump_val = 8'h40;
    step(); expect_out("j_target", 8'h40, 8'h10);
    jump = 1'b0; drive_jump = 1'b0;
    step(); expect_out("j_req_lo2", 8'h41, 8'h10);
    step(); expect_out("j_send_hi", 8'h9A, 8'h20);
    step(); expect_out("j_send_lo", 8'hBC, 8'h60);

    // Timeout: memory stalls from the next REQ_HI onward
    ack = 1'b0;
    step(); expect_out("t_enter", 8'h42, 8'h10);
    for (int i = 1; i < 15; i++) begin
      step(); expect_out("t_wait", 8'h42, 8'h10);
    end
    step(); expect_out("t_fault", 8'h42, 8'h90);
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("t_sticky", 8'h42, 8'h90);
    end
    ack = 1'b1;
    step(); expect_out("t_req_lo", 8'h43, 8'h90);
    step(); expect_out("t_send_hi", 8'h11, 8'hA0);
    step(); expect_out("t_send_lo", 8'h22, 8'hE0);
    step(); expect_out("t_next", 8'h44, 8'h90);
    step(); expect_out("t_req_lo2", 8'h45, 8'h90);
    jump = 1'b1; drive_jump = 1'b1; jump_val = 8'h10;
    step(); expect_out("t_clear", 8'h10, 8'h10);
    jump = 1'b0; drive_jump = 1'b0;

    // ena drop in REQ_LO rewinds to the instruction start
    step(); expect_out("e_req_lo", 8'h11, 8'h10);
    ena = 1'b0;
    step(); expect_out("e_rewind", 8'h10, 8'h00);
    ena = 1'b1;
    step(); expect_out("e_req_hi", 8'h10, 8'h10);
    step(); expect_out("e_req_lo2", 8'h11, 8'h10);
    step(); expect_out("e_send_hi", 8'h5E, 8'h20);
    step(); expect_out("e_send_lo", 8'h6F, 8'h60);

    // Asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 8'h00, 8'h00);
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(); expect_out("idle_ack_ignored", 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
